// File: rtl/fuzzy_t2_engine.sv
// Interval type-2 fuzzy inference engine: sequential scan of N_MF*N_MF rules
// followed by a restoring divide (Nie-Tan type reduction) with start/ready/valid.
module fuzzy_t2_engine #(
  parameter int          W       = 8,
  parameter int          N_MF    = 3,
  parameter logic [W-1:0] DEFAULT = 8'h80,
  localparam int         R       = N_MF * N_MF,
  localparam int         CNTW    = $clog2(R + 1)
) (
  input  logic                clk_0,
  input  logic                Srst,
  input  logic                start,
  output logic                ready,
  input  logic [N_MF*W-1:0]   g1_up,
  input  logic [N_MF*W-1:0]   g1_low,
  input  logic [N_MF*W-1:0]   g2_up,
  input  logic [N_MF*W-1:0]   g2_low,
  input  logic [R*W-1:0]      cons_c,
  output logic [W-1:0]        y_out,
  output logic                valid,
  output logic                no_fire,
  output logic [CNTW-1:0]     rule_cnt
);

  localparam int LR = $clog2(R);
  localparam int NW = 2 * W + 1 + LR;
  localparam int DW = W + 1 + LR;
  localparam int PW = 2 * W + 1;
  localparam int IW = (N_MF > 1) ? $clog2(N_MF) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DIV, DONE} state_t;

  function automatic logic [W-1:0] umin(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              no_fire_q, no_fire_d;
  logic [W-1:0]      y_q, y_d;
  logic [CNTW-1:0]   rule_cnt_q, rule_cnt_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]     num_q, num_d;
  logic [DW-1:0]     den_q, den_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [N_MF*W-1:0] g1u_q, g1u_d, g1l_q, g1l_d, g2u_q, g2u_d, g2l_q, g2l_d;
  logic [R*W-1:0]    cons_q, cons_d;

  logic [W-1:0]  u1, l1, u2, l2, lo1, lo2, fu, fl, c_sel;
  logic [W:0]    wsum;
  logic [PW-1:0] prod;
  logic [DW:0]   trial, diff;
  logic          qbit;
  logic [DW-1:0] rem_new;

  // Rule evaluation for the current (i,j); lower grades clamped to their upper.
  always_comb begin
    u1    = g1u_q[int'(i_q)*W +: W];
    l1    = g1l_q[int'(i_q)*W +: W];
    u2    = g2u_q[int'(j_q)*W +: W];
    l2    = g2l_q[int'(j_q)*W +: W];
    c_sel = cons_q[(int'(i_q)*N_MF + int'(j_q))*W +: W];
    lo1   = umin(l1, u1);
    lo2   = umin(l2, u2);
    fu    = umin(u1, u2);
    fl    = umin(lo1, lo2);
    wsum  = {1'b0, fu} + {1'b0, fl};
    prod  = PW'(wsum) * PW'(c_sel);
  end

  // Restoring divide step: upper NUM bits are the partial remainder, lower W bits
  // shift out dividend bits and shift in quotient bits.
  always_comb begin
    trial   = {num_q[NW-1:W], num_q[W-1]};
    diff    = trial - {1'b0, den_q};
    qbit    = ~diff[DW];
    rem_new = qbit ? diff[DW-1:0] : trial[DW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    no_fire_d  = no_fire_q;
    y_d        = y_q;
    rule_cnt_d = rule_cnt_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    den_d      = den_q;
    i_d        = i_q;
    j_d        = j_q;
    bit_d      = bit_q;
    g1u_d      = g1u_q;
    g1l_d      = g1l_q;
    g2u_d      = g2u_q;
    g2l_d      = g2l_q;
    cons_d     = cons_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start && ready_q) begin
          state_d = LOAD;
          ready_d = 1'b0;
          num_d   = '0;
          den_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        g1u_d   = g1_up;
        g1l_d   = g1_low;
        g2u_d   = g2_up;
        g2l_d   = g2_low;
        cons_d  = cons_c;
        i_d     = '0;
        j_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (fu != '0) begin
          num_d = num_q + NW'(prod);
          den_d = den_q + DW'(wsum);
          cnt_d = cnt_q + CNTW'(1);
        end
        if (j_q == IW'(N_MF - 1)) begin
          j_d = '0;
          if (i_q == IW'(N_MF - 1)) begin
            i_d     = '0;
            bit_d   = '0;
            state_d = DIV;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DIV: begin
        if (den_q != '0) num_d = {rem_new, num_q[W-2:0], qbit};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(W - 1)) state_d = DONE;
      end
      DONE: begin
        y_d        = (den_q == '0) ? DEFAULT : num_q[W-1:0];
        no_fire_d  = (den_q == '0);
        rule_cnt_d = cnt_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (!Srst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      no_fire_q  <= 1'b0;
      y_q        <= '0;
      rule_cnt_q <= '0;
      cnt_q      <= '0;
      num_q      <= '0;
      den_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      no_fire_q  <= no_fire_d;
      y_q        <= y_d;
      rule_cnt_q <= rule_cnt_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      den_q      <= den_d;
      i_q        <= i_d;
      j_q        <= j_d;
      bit_q      <= bit_d;
    end
  end

  // Captured operands: only meaningful after LOAD, so left unreset.
  always_ff @(posedge clk_0) begin
    g1u_q  <= g1u_d;
    g1l_q  <= g1l_d;
    g2u_q  <= g2u_d;
    g2l_q  <= g2l_d;
    cons_q <= cons_d;
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign no_fire  = no_fire_q;
  assign y_out    = y_q;
  assign rule_cnt = rule_cnt_q;

endmodule

// File: tb/tb_fuzzy_t2_engine.sv
// Directed bench for fuzzy_t2_engine (W=8, N_MF=3) with hand-computed results.
module tb_fuzzy_t2_engine;

  localparam int W    = 8;
  localparam int N_MF = 3;
  localparam int R    = 9;
  localparam int CNTW = 4;

  logic              clk_0 = 1'b0;
  logic              Srst;
  logic              start;
  logic              ready;
  logic [N_MF*W-1:0] g1_up, g1_low, g2_up, g2_low;
  logic [R*W-1:0]    cons_c;
  logic [W-1:0]      y_out;
  logic              valid;
  logic              no_fire;
  logic [CNTW-1:0]   rule_cnt;

  int checks = 0;
  int errors = 0;

  fuzzy_t2_engine #(.W(W), .N_MF(N_MF), .DEFAULT(8'h80)) dut (
    .clk_0(clk_0), .Srst(Srst), .start(start), .ready(ready),
    .g1_up(g1_up), .g1_low(g1_low), .g2_up(g2_up), .g2_low(g2_low),
    .cons_c(cons_c), .y_out(y_out), .valid(valid), .no_fire(no_fire),
    .rule_cnt(rule_cnt)
  );

  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    g1_up = '0; g1_low = '0; g2_up = '0; g2_low = '0; cons_c = '0;
  endtask

  task automatic set_mf(input int inp, input int k, input logic [7:0] up, input logic [7:0] lo);
    if (inp == 1) begin
      g1_up[k*W +: W] = up; g1_low[k*W +: W] = lo;
    end else begin
      g2_up[k*W +: W] = up; g2_low[k*W +: W] = lo;
    end
  endtask

  task automatic set_c(input int r, input logic [7:0] v);
    cons_c[r*W +: W] = v;
  endtask

  task automatic load_t1();
    clear_in();
    set_mf(1, 0, 8'd200, 8'd100);
    set_mf(2, 1, 8'd255, 8'd150);
    set_c(1, 8'd80);
  endtask

  task automatic load_t2();
    clear_in();
    set_mf(1, 0, 8'd100, 8'd50); set_mf(1, 1, 8'd100, 8'd50);
    set_mf(2, 0, 8'd100, 8'd50); set_mf(2, 1, 8'd100, 8'd50);
    set_c(0, 8'd40); set_c(1, 8'd100); set_c(3, 8'd100); set_c(4, 8'd160);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 60) begin
      @(negedge clk_0);
      n++;
    end
    check({tag, " ready"}, 32'(ready), 32'd1);
  endtask

  // Launch one operation with the currently driven inputs and check its result.
  task automatic run(input string tag, input logic [7:0] ey, input logic enf, input logic [3:0] ecnt);
    logic [7:0] y0;
    int lat;
    bit moved;
    wait_ready(tag);
    y0 = y_out;
    moved = 0;
    start = 1'b1;
    @(negedge clk_0);
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      if (y_out !== y0) moved = 1;
      @(negedge clk_0);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd19);
    check({tag, " ready_at_valid"}, 32'(ready), 32'd0);
    check({tag, " y_out"}, 32'(y_out), 32'(ey));
    check({tag, " no_fire"}, 32'(no_fire), 32'(enf));
    check({tag, " rule_cnt"}, 32'(rule_cnt), 32'(ecnt));
    check({tag, " y_hold"}, 32'(moved), 32'd0);
    @(negedge clk_0);
    check({tag, " valid_pulse"}, 32'(valid), 32'd0);
    check({tag, " ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int nv;
    logic [7:0] yv;
    logic [3:0] cv;

    Srst = 1'b0;
    start = 1'b0;
    clear_in();
    repeat (3) @(negedge clk_0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst valid", 32'(valid), 32'd0);
    check("rst y_out", 32'(y_out), 32'd0);
    check("rst no_fire", 32'(no_fire), 32'd0);
    check("rst rule_cnt", 32'(rule_cnt), 32'd0);
    Srst = 1'b1;
    @(negedge clk_0);

    // T1: single rule (0,1): w=200+100, y=80
    load_t1();
    run("t1", 8'd80, 1'b0, 4'd1);

    // T2: four equal-weight rules, mean of 40,100,100,160
    load_t2();
    run("t2", 8'd100, 1'b0, 4'd4);

    // T3: nothing fires
    clear_in();
    run("t3", 8'h80, 1'b1, 4'd0);

    // T4: lower above upper on a single rule
    clear_in();
    set_mf(1, 2, 8'd60, 8'd200);
    set_mf(2, 2, 8'd255, 8'd255);
    set_c(8, 8'd30);
    run("t4", 8'd30, 1'b0, 4'd1);

    // T4b: clamping changes the weighting: (90*3+30)/4 = 75 (69 without clamp)
    clear_in();
    set_mf(1, 0, 8'd60, 8'd60);
    set_mf(1, 2, 8'd60, 8'd200);
    set_mf(2, 0, 8'd255, 8'd255);
    set_mf(2, 2, 8'd255, 8'd255);
    set_c(0, 8'd90); set_c(2, 8'd90); set_c(6, 8'd90); set_c(8, 8'd30);
    run("t4b", 8'd75, 1'b0, 4'd4);

    // T7: floor: (200*10 + 100*21)/300 = 13.67 -> 13
    clear_in();
    set_mf(1, 0, 8'd100, 8'd100);
    set_mf(2, 0, 8'd100, 8'd100);
    set_mf(2, 1, 8'd50, 8'd50);
    set_c(0, 8'd10); set_c(1, 8'd21);
    run("t7", 8'd13, 1'b0, 4'd2);

    // T5: start pulses while busy and inputs changed after LOAD
    load_t1();
    wait_ready("t5");
    start = 1'b1;
    @(negedge clk_0);
    start = 1'b0;
    @(negedge clk_0);
    load_t2();
    nv = 0;
    yv = '0;
    cv = '0;
    for (int c = 0; c < 40; c++) begin
      start = (c < 14) && (c % 2 == 0);
      @(negedge clk_0);
      if (valid) begin
        nv++;
        yv = y_out;
        cv = rule_cnt;
      end
    end
    start = 1'b0;
    check("t5 valid_count", 32'(nv), 32'd1);
    check("t5 y_out", 32'(yv), 32'd80);
    check("t5 rule_cnt", 32'(cv), 32'd1);

    // T6: reset in the middle of SCAN aborts the operation
    load_t2();
    wait_ready("t6");
    start = 1'b1;
    @(negedge clk_0);
    start = 1'b0;
    repeat (5) @(negedge clk_0);
    Srst = 1'b0;
    @(negedge clk_0);
    check("t6 ready", 32'(ready), 32'd1);
    check("t6 valid", 32'(valid), 32'd0);
    check("t6 y_out", 32'(y_out), 32'd0);
    check("t6 rule_cnt", 32'(rule_cnt), 32'd0);
    Srst = 1'b1;
    nv = 0;
    repeat (25) begin
      @(negedge clk_0);
      if (valid) nv++;
    end
    check("t6 no_valid", 32'(nv), 32'd0);
    run("t6 rerun", 8'd100, 1'b0, 4'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
